// File: rtl/cpu_io_bridge.sv
`default_nettype none
// ============================================================================
// Module  : cpu_io_bridge
// Purpose : Z80 I/O strobe synchroniser/deglitcher issuing one VDP request
//           per bus access. Optional access counters: CPU_IO_ACCESS_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module cpu_io_bridge #(
  parameter int FILTER_LEN = 3,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        csr_n,
  input  logic        csw_n,
  input  logic [1:0]  mode,
  input  logic [7:0]  cd_in,
  input  logic [7:0]  vdp_dbi,
  output logic        req,
  output logic        wrt,
  output logic [15:0] adr,
  output logic [7:0]  dbo,
  output logic [7:0]  rd_data,
  output logic        rd_oe,
  output logic        stuck,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count
);

  localparam logic [3:0]  c_filter_len = 4'(FILTER_LEN);
  localparam logic [15:0] c_timeout    = 16'(TIMEOUT);
  localparam logic [15:0] c_timeout_m1 = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_IGNORE = 2'd2
  } state_t;

  // Bit 0 carries the read strobe, bit 1 the write strobe.
  logic [1:0]  r_s1;
  logic [1:0]  r_s2;
  logic [1:0]  r_filt;
  logic [3:0]  r_fcnt [2];
  logic [1:0]  r_settle;

  state_t      r_state;
  logic        r_armed;
  logic        r_req;
  logic        r_wrt;
  logic        r_rd_cap;
  logic [1:0]  r_mode;
  logic [7:0]  r_dbo;
  logic [7:0]  r_rd_data;
  logic [15:0] r_to_cnt;
  logic        r_stuck;

  logic        w_both_high;
  logic        w_both_low;

  assign w_both_high = (r_filt == 2'b11);
  assign w_both_low  = (r_filt == 2'b00);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1     <= 2'b11;
      r_s2     <= 2'b11;
      r_filt   <= 2'b11;
      r_settle <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_fcnt[i] <= 4'd0;
      end
    end else begin
      r_s1     <= {csw_n, csr_n};
      r_s2     <= r_s1;
      r_settle <= {r_settle[0], 1'b1};
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] != r_filt[i]) begin
          if (r_fcnt[i] + 4'd1 == c_filter_len) begin
            r_filt[i] <= r_s2[i];
            r_fcnt[i] <= 4'd0;
          end else begin
            r_fcnt[i] <= r_fcnt[i] + 4'd1;
          end
        end else begin
          r_fcnt[i] <= 4'd0;
        end
      end
    end
  end

  // r_armed only sets once the synchroniser holds real post-reset samples,
  // so a strobe still held across reset release cannot produce a request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_armed   <= 1'b0;
      r_req     <= 1'b0;
      r_wrt     <= 1'b0;
      r_rd_cap  <= 1'b0;
      r_mode    <= 2'b00;
      r_dbo     <= 8'h00;
      r_rd_data <= 8'h00;
      r_to_cnt  <= 16'd0;
      r_stuck   <= 1'b0;
    end else begin
      r_req    <= 1'b0;
      r_wrt    <= 1'b0;
      r_rd_cap <= 1'b0;
      if (r_rd_cap) begin
        r_rd_data <= vdp_dbi;
      end
      case (r_state)
        ST_IDLE: begin
          r_to_cnt <= 16'd0;
          r_stuck  <= 1'b0;
          if (w_both_high) begin
            if (r_settle[1] && (r_s2 == 2'b11)) begin
              r_armed <= 1'b1;
            end
          end else if (w_both_low) begin
            r_state <= ST_IGNORE;
          end else if (r_armed) begin
            r_req    <= 1'b1;
            r_wrt    <= ~r_filt[1];
            r_rd_cap <= r_filt[1];
            r_mode   <= mode;
            if (!r_filt[1]) begin
              r_dbo <= cd_in;
            end
            r_state <= ST_ACTIVE;
          end
        end
        ST_ACTIVE, ST_IGNORE: begin
          if (w_both_high) begin
            r_state  <= ST_IDLE;
            r_to_cnt <= 16'd0;
            r_stuck  <= 1'b0;
          end else begin
            if (r_to_cnt == c_timeout_m1) begin
              r_stuck <= 1'b1;
            end
            if (r_to_cnt != c_timeout) begin
              r_to_cnt <= r_to_cnt + 16'd1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CPU_IO_ACCESS_CNT_EN
  logic [15:0] r_wr_count;
  logic [15:0] r_rd_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_count <= 16'd0;
      r_rd_count <= 16'd0;
    end else if (r_req) begin
      if (r_wrt) begin
        r_wr_count <= r_wr_count + 16'd1;
      end else begin
        r_rd_count <= r_rd_count + 16'd1;
      end
    end
  end

  assign wr_count = r_wr_count;
  assign rd_count = r_rd_count;
`else
  assign wr_count = 16'd0;
  assign rd_count = 16'd0;
`endif

  assign req     = r_req;
  assign wrt     = r_wrt;
  assign adr     = {14'd0, r_mode};
  assign dbo     = r_dbo;
  assign rd_data = r_rd_data;
  assign rd_oe   = ~r_filt[0];
  assign stuck   = r_stuck;

endmodule
`default_nettype wire

// File: doc/cpu_io_bridge.md
Name: cpu_io_bridge

Overview:
- Upstream stage between the raw Z80 I/O strobes (ports $98-$9B) and the VDP CPU interface (REQ/WRT/ADR/DBO/DBI).
- Synchronises and deglitches the decoded read and write strobes, then issues exactly one single-cycle request per bus access.
- Latches port address and write data, captures VDP read data, and flags strobes that stay asserted too long.
- Runs on the 27 MHz VDP clock domain.

Parameters:
- FILTER_LEN, 3, consecutive equal synced samples needed before a filtered strobe changes state (1..15).
- TIMEOUT, 1024, clk cycles in ACTIVE before stuck asserts (2..65535).

Ports:
- clk  input  1  VDP pixel clock (27 MHz).
- reset_n  input  1  Asynchronous active-low reset.
- csr_n  input  1  Raw decoded read strobe, async, active low.
- csw_n  input  1  Raw decoded write strobe, async, active low.
- mode  input  2  CPU address bits A1:A0, port select.
- cd_in  input  8  CPU data bus, input side.
- vdp_dbi  input  8  VDP read data (combinational from VDP).
- req  output  1  Single-cycle request to VDP.
- wrt  output  1  1 = write access; valid while req=1.
- adr  output  16  {14'b0, latched mode}.
- dbo  output  8  Latched write data.
- rd_data  output  8  Captured VDP read data, drives the CPU bus.
- rd_oe  output  1  CPU bus output enable, equal to ~filtered read strobe.
- stuck  output  1  Access has exceeded TIMEOUT.
- wr_count  output  16  Accepted write count (optional feature).
- rd_count  output  16  Accepted read count (optional feature).

Behaviour:
- Reset values:
  - req, wrt, stuck, rd_oe = 0.
  - adr, dbo, rd_data, both counts = 0.
  - Sync flops and filtered strobes = 1.
  - FSM = IDLE.
- Reset is asynchronous. Asserting it mid-access aborts immediately; no req is issued after release until both filtered strobes have been seen high in IDLE.
- Synchroniser: 2 flops per strobe (s1, s2).
- Filter, per strobe:
  - The counter increments on each edge where s2 != filtered output.
  - On reaching FILTER_LEN, the output takes s2 and the counter clears.
  - Any edge with s2 == output clears the counter, so glitches shorter than FILTER_LEN cycles are rejected.
- Latency: with raw strobe low first sampled at edge E0:
  - Filtered strobe goes low after edge E(FILTER_LEN+1).
  - req is high for the cycle after edge E(FILTER_LEN+2).
  - rd_data is captured at edge E(FILTER_LEN+3).
- FSM states: IDLE, ACTIVE, IGNORE.
- IDLE:
  - Exactly one filtered strobe low:
    - Latch adr from mode and wrt from ~fw.
    - For a write, also latch dbo from cd_in.
    - req = 1 for one cycle; go to ACTIVE.
  - Both low: no req; go to IGNORE.
  - Both high: stay in IDLE.
- ACTIVE:
  - req = 0, wrt = 0.
  - First cycle of a read: rd_data <= vdp_dbi.
  - Timeout counter increments each cycle; when it reaches TIMEOUT, stuck = 1 (sticky until exit).
  - Both filtered strobes high: go to IDLE and clear stuck and the counter.
  - A change of which strobe is low (e.g. read then write without release) does NOT issue a new req. Release of both strobes is mandatory first.
- IGNORE: wait for both strobes high, then go to IDLE. The timeout and stuck rules are the same as in ACTIVE.
- rd_data holds its value between reads. rd_oe is combinational from the filtered read strobe.
- adr[15:2] is always 0.

Optional Feature:
- Macro: CPU_IO_ACCESS_CNT_EN.
- Defined:
  - wr_count and rd_count increment by 1 on each req with wrt=1 and wrt=0 respectively.
  - 16-bit counters that wrap 65535 -> 0.
  - Not incremented for IGNORE accesses.
- Undefined: both outputs are tied to 0 and no counter flops are inferred.

Test Plan:
- Write: csw_n low 12 cycles, mode=2'b01, cd_in=8'hA5, FILTER_LEN=3 -> one req pulse after the 6th edge from E0, with wrt=1, adr=16'h0001, dbo=8'hA5. wr_count=1 if feature enabled.
- Read: csr_n low 12 cycles, vdp_dbi=8'h3C -> one req with wrt=0; rd_data=8'h3C one cycle later and held after release; rd_oe follows the filtered strobe.
- Glitch: csw_n low for 2 cycles then high -> no req, filtered strobe never changes, wr_count unchanged.
- Both strobes low together for 10 cycles -> no req, FSM passes through IGNORE to IDLE, counts unchanged.
- Stuck: TIMEOUT=16, csr_n held low 40 cycles -> stuck rises 16 cycles after entering ACTIVE and clears after both strobes release.
- Reset: reset_n pulsed low while in ACTIVE with csw_n held low -> all outputs return to reset values; no new req until csw_n releases and re-asserts.
